// File: rtl/demux_dispatcher.sv
// Round-robin 1:4 dispatcher: one valid/ready input stream spread over four channels, skipping masked ones.
// Optional per-channel completed-transfer counters when DEMUX_DISPATCHER_CNT_EN is defined.
module demux_dispatcher #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        chan_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              busy
`ifdef DEMUX_DISPATCHER_CNT_EN
    ,
    output logic [63:0]       beat_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [1:0]        sel_reg, sel_next;
    logic [DATA_W-1:0] data_reg, data_next;

    logic [3:0] rot_en;
    logic [1:0] offset;
    logic [1:0] nxt;
    logic       any_en;
    logic       done;
    logic       accept;

    // Enable mask rotated so bit 0 is the channel at ptr; lowest set bit wins.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_en[gi] = chan_en[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_en[k]) begin
                offset = 2'(k);
            end
        end
    end

    assign nxt      = ptr_reg + offset;
    assign any_en   = |chan_en;
    assign done     = (state_reg == HOLD) && out_ready[sel_reg];
    assign in_ready = any_en && ((state_reg == IDLE) || done);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        data_next  = data_reg;
        if (accept) begin
            state_next = HOLD;
            ptr_next   = nxt + 2'd1;
            sel_next   = nxt;
            data_next  = in_data;
        end else if (done) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
        end
    end

    // Outputs come only from registers, so out_valid never follows out_ready combinationally.
    assign out_valid = (state_reg == HOLD) ? (4'd1 << sel_reg) : 4'd0;
    assign out_data  = data_reg;
    assign sel       = sel_reg;
    assign busy      = (state_reg == HOLD);

`ifdef DEMUX_DISPATCHER_CNT_EN
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 16'd0;
                end else if (done && (sel_reg == 2'(gi))) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign beat_cnt[16*gi +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed self-checking bench for demux_dispatcher; inputs driven and outputs sampled on the falling edge.
module tb_demux_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] chan_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic       busy;
`ifdef DEMUX_DISPATCHER_CNT_EN
    logic [63:0] beat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_dispatcher #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .chan_en   (chan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy)
`ifdef DEMUX_DISPATCHER_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    task automatic test_reset;
        rst = 1'b1; chan_en = 4'hF; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("reset: out_valid=%b busy=%b sel=%0d in_ready=%b", out_valid, busy, sel, in_ready);
    endtask

    task automatic test_rotation;
        logic [3:0] exp_v;
        out_ready = 4'hF; chan_en = 4'hF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            in_valid = (k < 8);
            in_data  = 8'hA0 + 8'(k);
            #1;
            if (k > 0) begin
                exp_v = 4'd1 << ((k - 1) % 4);
                checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rot_out_valid beat %0d got %b want %b", k - 1, out_valid, exp_v); end
                checks++; if (out_data !== 8'hA0 + 8'(k - 1)) begin errors++; $display("FAIL rot_out_data beat %0d got %h want %h", k - 1, out_data, 8'hA0 + 8'(k - 1)); end
                $display("rotation beat %0d: out_valid=%b out_data=%h", k - 1, out_valid, out_data);
            end
            if (k < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rot_in_ready beat %0d got %b want 1", k, in_ready); end
            end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rot_drain got %b want 0000", out_valid); end
`ifdef DEMUX_DISPATCHER_CNT_EN
        checks++; if (beat_cnt !== {4{16'd2}}) begin errors++; $display("FAIL rot_beat_cnt got %h want %h", beat_cnt, {4{16'd2}}); end
`endif
    endtask

    task automatic test_mask_skip;
        logic [1:0] exp_ch [4];
        exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1; exp_ch[3] = 2'd3;
        chan_en = 4'b1010; out_ready = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k < 4);
            in_data  = 8'hB0 + 8'(k);
            #1;
            if (k > 0) begin
                checks++; if (out_valid !== (4'd1 << exp_ch[k - 1])) begin errors++; $display("FAIL mask_out_valid beat %0d got %b want %b", k - 1, out_valid, 4'd1 << exp_ch[k - 1]); end
                checks++; if (sel !== exp_ch[k - 1]) begin errors++; $display("FAIL mask_sel beat %0d got %0d want %0d", k - 1, sel, exp_ch[k - 1]); end
                $display("mask skip beat %0d: sel=%0d out_valid=%b", k - 1, sel, out_valid);
            end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mask_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_backpressure;
        // Pointer is 0 here; the first beat goes to channel 0, which stalls.
        chan_en = 4'hF; out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        in_data = 8'h66;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 0001", k, out_valid); end
            checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL bp_out_data cyc %0d got %h want 55", k, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, in_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy cyc %0d got %b want 1", k, busy); end
            $display("backpressure cyc %0d: out_valid=%b out_data=%h in_ready=%b", k, out_valid, out_data, in_ready);
            @(negedge clk);
        end
        out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_next_out_valid got %b want 0010", out_valid); end
        checks++; if (out_data !== 8'h66) begin errors++; $display("FAIL bp_next_out_data got %h want 66", out_data); end
        $display("backpressure release: out_valid=%b out_data=%h", out_valid, out_data);
        @(negedge clk);
    endtask

    task automatic test_mask_hold;
        // Pointer is 2; hold a beat on channel 2 then remove every enable.
        chan_en = 4'hF; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0; chan_en = 4'h0;
        #1;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL mh_out_valid got %b want 0100", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mh_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL mh_still_held got %b want 0100", out_valid); end
        checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL mh_out_data got %h want 77", out_data); end
        out_ready = 4'b0100; in_valid = 1'b1; in_data = 8'h88;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mh_done_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mh_delivered got %b want 0000", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mh_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mh_disabled_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mh_no_accept got %b want 0", busy); end
        in_valid = 1'b0; chan_en = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mh_reenable_in_ready got %b want 1", in_ready); end
        $display("mask hold: delivered on ch2, in_ready=%b after re-enable", in_ready);
    endtask

    task automatic test_reset_mid_hold;
        // Pointer is 3; hold a beat on channel 3, then reset over it.
        chan_en = 4'hF; out_ready = 4'h0; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL rmh_held got %b want 1000", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rmh_out_valid got %b want 0000", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmh_busy got %b want 0", busy); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rmh_sel got %0d want 0", sel); end
`ifdef DEMUX_DISPATCHER_CNT_EN
        checks++; if (beat_cnt !== 64'd0) begin errors++; $display("FAIL rmh_beat_cnt got %h want 0", beat_cnt); end
`endif
        out_ready = 4'hF; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL rmh_next_ch got %b want 0001", out_valid); end
        checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL rmh_next_data got %h want aa", out_data); end
        $display("reset mid-hold: next beat out_valid=%b out_data=%h", out_valid, out_data);
        @(negedge clk);
    endtask

    task automatic test_single_channel;
        chan_en = 4'b0100; out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = (k < 3);
            in_data  = 8'hC0 + 8'(k);
            #1;
            if (k > 0) begin
                checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_out_valid beat %0d got %b want 0100", k - 1, out_valid); end
                checks++; if (out_data !== 8'hC0 + 8'(k - 1)) begin errors++; $display("FAIL single_out_data beat %0d got %h want %h", k - 1, out_data, 8'hC0 + 8'(k - 1)); end
                $display("single channel beat %0d: out_valid=%b out_data=%h", k - 1, out_valid, out_data);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_mask_skip();
        test_backpressure();
        test_mask_hold();
        test_reset_mid_hold();
        test_single_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Sequencing controller for the 1:4 demux datapath.
- Accepts one valid/ready input stream and distributes beats round-robin across 4 output channels, skipping channels disabled by a runtime mask.
- A single holding register drives the shared output data bus. The registered channel select steers out_valid.
- Sits between a single producer and four consumer channels.

Parameters:
DATA_W, 8, width of in_data / out_data

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
chan_en  input  4  per-channel enable mask; bit i=1 means channel i participates in rotation
in_valid  input  1  producer has a beat
in_ready  output  1  dispatcher accepts beat this cycle
in_data  input  DATA_W  producer data
out_valid  output  4  one-hot; bit i = beat presented to channel i
out_ready  input  4  per-channel consumer ready
out_data  output  DATA_W  shared data bus, meaningful only for the channel whose out_valid is high
sel  output  2  registered channel index of held beat (demux select)
busy  output  1  holding register occupied (state HOLD)

Behaviour:
- Reset (rst=1 at clk edge) clears state to IDLE and sets ptr=0, sel=0, out_data=0.
  - Outputs after reset: out_valid=0, busy=0.
  - rst mid-HOLD discards the held beat; it is never delivered.
- State IDLE: holding register empty.
- State HOLD: holding register full; out_valid = one-hot(sel), out_data = held data.
- nxt = first channel i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with chan_en[i]=1.
- any_en = |chan_en.
- done = (state==HOLD) && out_ready[sel].
- in_ready = any_en && (state==IDLE || done). This is combinational from out_ready, which gives full-throughput pass-through.
- Accept = in_valid && in_ready. On accept:
  - data captured;
  - sel <= nxt;
  - ptr <= (nxt+1) mod 4 (2-bit wrap);
  - state <= HOLD.
- done without accept: state <= IDLE, out_valid drops next cycle.
- done with accept in the same cycle: stay in HOLD with the new beat on the next channel. Sustained rate is 1 beat/cycle.
- Latency: beat accepted at edge N is presented (out_valid high) from cycle N+1.
- Held beat stays on its latched sel even if chan_en[sel] clears while held. The mask only affects future selection.
- chan_en=0: in_ready=0 and no new beats are accepted; a held beat still completes.
- Single enabled channel: every beat goes to that channel; ptr = that channel+1.
- out_valid is never asserted for more than one channel and never depends combinationally on out_ready.
- out_data is held stable while out_valid is high and not done.
- ptr advances only on accept, never on done alone.

Optional Feature:
Macro DEMUX_DISPATCHER_CNT_EN.
- Defined: adds output port beat_cnt, 64 bits. beat_cnt[16*i+15:16*i] is a 16-bit count of completed transfers (done) on channel i.
  - Increments on done for sel=i.
  - Wraps 16'hFFFF -> 0.
  - Cleared by rst.
- Not defined: port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 two cycles -> out_valid=4'b0000, busy=0, sel=0, in_ready=1 with chan_en=4'hF.
- Full rotation, all ready: chan_en=4'hF, out_ready=4'hF, in_valid=1 with data A0..A7 -> one beat per cycle, out_valid sequence 0001,0010,0100,1000,0001..., each appearing one cycle after accept, data in order.
- Mask skip: chan_en=4'b1010, out_ready=4'hF, 4 beats -> delivered to channels 1,3,1,3, sel=1,3,1,3.
- Backpressure: chan_en=4'hF, out_ready[0]=0 for 5 cycles -> beat 0x55 held on out_valid=0001 and out_data=0x55 stable, in_ready=0, busy=1. Raising out_ready[0] delivers it; the next beat goes to channel 1.
- Mask change while held, plus all-disabled: hold a beat on channel 2 with out_ready=0, then set chan_en=0 -> beat still delivered on channel 2 when out_ready[2]=1. Afterwards in_ready=0 until chan_en is nonzero.
- Reset mid-HOLD: beat held on channel 3, rst=1 -> next cycle out_valid=0, busy=0, ptr=0. The next beat goes to channel 0. With DEMUX_DISPATCHER_CNT_EN, all counters read 0.
